// File: rtl/go_request_ctrl.sv
// Initiator-side controller for the LED counter: debounces the GO button, issues a timed
// active-low go request, then supervises the counter's done handshake with a timeout.
module go_request_ctrl #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int GO_HOLD_CYCLES  = 3000000,
    parameter int TIMEOUT_CYCLES  = 60000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go_btn,
    input  logic       done_sig,
    output logic       go_n,
    output logic       busy,
    output logic       run_done,
    output logic       timeout_err,
    output logic [7:0] run_count
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(GO_HOLD_CYCLES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    // Gray-ordered so every legal transition flips at most one state bit where possible.
    localparam logic [1:0] IDLE       = 2'b00;
    localparam logic [1:0] REQUEST    = 2'b01;
    localparam logic [1:0] WAIT_DONE  = 2'b11;
    localparam logic [1:0] WAIT_CLEAR = 2'b10;

    logic              go_meta, go_sync;
    logic              done_meta, done_sync;
    logic              btn_level;
    logic [DB_W-1:0]   db_cnt;
    logic              press_evt;
    logic [1:0]        state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              start_run, done_hit, tmo_hit;
    logic              hold_zero, tmo_zero;

    // Synchronizers reset to the idle levels: button released (high), done low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            go_meta   <= 1'b1;
            go_sync   <= 1'b1;
            done_meta <= 1'b0;
            done_sync <= 1'b0;
        end else begin
            go_meta   <= go_btn;
            go_sync   <= go_meta;
            done_meta <= done_sig;
            done_sync <= done_meta;
        end
    end

    // btn_level keeps the raw button polarity, so 1 means released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_level <= 1'b1;
            db_cnt    <= '0;
            press_evt <= 1'b0;
        end else begin
            press_evt <= 1'b0;
            if (go_sync != btn_level) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    btn_level <= go_sync;
                    db_cnt    <= '0;
                    press_evt <= ~go_sync;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign hold_zero = (hold_cnt == '0);
    assign tmo_zero  = (tmo_cnt == '0);
    assign start_run = (state == IDLE) && press_evt;

    // A done seen in WAIT_DONE takes priority over a simultaneous timeout expiry.
    always_comb begin
        state_nxt = state;
        done_hit  = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (press_evt) state_nxt = REQUEST;
            end
            REQUEST: begin
                if (tmo_zero) begin
                    state_nxt = IDLE;
                    tmo_hit   = 1'b1;
                end else if (hold_zero) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done_sync) begin
                    state_nxt = WAIT_CLEAR;
                    done_hit  = 1'b1;
                end else if (tmo_zero) begin
                    state_nxt = IDLE;
                    tmo_hit   = 1'b1;
                end
            end
            WAIT_CLEAR: begin
                if (!done_sync) begin
                    state_nxt = IDLE;
                end else if (tmo_zero) begin
                    state_nxt = IDLE;
                    tmo_hit   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // go_n and busy are registered from the next state so the counter sees glitch-free levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            go_n        <= 1'b1;
            busy        <= 1'b0;
            run_done    <= 1'b0;
            timeout_err <= 1'b0;
            run_count   <= '0;
            hold_cnt    <= '0;
            tmo_cnt     <= '0;
        end else begin
            state    <= state_nxt;
            go_n     <= (state_nxt != REQUEST);
            busy     <= (state_nxt != IDLE);
            run_done <= done_hit;
            if (done_hit) run_count <= run_count + 8'd1;
            if (start_run) begin
                timeout_err <= 1'b0;
                hold_cnt    <= HOLD_W'(GO_HOLD_CYCLES - 1);
                tmo_cnt     <= TMO_W'(TIMEOUT_CYCLES - 1);
            end else begin
                if (state == REQUEST && !hold_zero) hold_cnt <= hold_cnt - HOLD_W'(1);
                if (state != IDLE && !tmo_zero) tmo_cnt <= tmo_cnt - TMO_W'(1);
                if (tmo_hit) timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_go_request_ctrl.sv
// Randomized bench for go_request_ctrl: each run's expected output events are computed from
// the timing rules and queued; a monitor matches observed events against the queue.
module tb_go_request_ctrl;

    localparam int DB   = 4;
    localparam int HOLD = 8;
    localparam int TMO  = 100;

    localparam int EV_GOFALL  = 0;
    localparam int EV_GORISE  = 1;
    localparam int EV_RUNDONE = 2;
    localparam int EV_TERR    = 3;
    localparam int EV_IDLE    = 4;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go_btn = 1'b1;
    logic       done_sig = 1'b0;
    logic       go_n, busy, run_done, timeout_err;
    logic [7:0] run_count;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   model_count = 0;
    ev_t  exp_q[$];
    logic prev_go_n = 1'b1;
    logic prev_busy = 1'b0;
    logic prev_terr = 1'b0;

    go_request_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .GO_HOLD_CYCLES (HOLD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .go_btn     (go_btn),
        .done_sig   (done_sig),
        .go_n       (go_n),
        .busy       (busy),
        .run_done   (run_done),
        .timeout_err(timeout_err),
        .run_count  (run_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (cyc > 80000) begin
            $display("[TB] FAIL watchdog: cycle=%0d exceeded limit=80000", cyc);
            $fatal(1, "[TB] watchdog expired");
        end
    end

    function automatic string evName(input int k);
        case (k)
            EV_GOFALL:  return "go_n_fall";
            EV_GORISE:  return "go_n_rise";
            EV_RUNDONE: return "run_done";
            EV_TERR:    return "timeout_err_rise";
            EV_IDLE:    return "busy_fall";
            default:    return "unknown";
        endcase
    endfunction

    function automatic void push(input int k, input int c, input int v);
        exp_q.push_back('{kind: k, cyc: c, val: v});
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic handleEvent(input int k, input int v);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected %s at cycle %0d (val=%0d), expected no event",
                     evName(k), cyc, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.val != v) begin
                fails++;
                $display("[TB] FAIL event: got %s cyc=%0d val=%0d, expected %s cyc=%0d val=%0d",
                         evName(k), cyc, v, evName(e.kind), e.cyc, e.val);
            end
        end
    endtask

    // Monitor: sample half a cycle after each edge and turn output changes into events.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_go_n && !go_n) handleEvent(EV_GOFALL, {30'd0, busy, timeout_err});
            if (!prev_go_n && go_n) handleEvent(EV_GORISE, {31'd0, busy});
            if (run_done) handleEvent(EV_RUNDONE, {24'd0, run_count});
            if (!prev_terr && timeout_err) handleEvent(EV_TERR, {24'd0, run_count});
            if (prev_busy && !busy) handleEvent(EV_IDLE, {31'd0, go_n});
        end
        prev_go_n = go_n;
        prev_busy = busy;
        prev_terr = timeout_err;
    end

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    // One press-driven run. Button is driven low right after edge p; dly/len place done_sig
    // relative to the request start; extra adds a second, to-be-ignored press while busy.
    task automatic applyStimulus(input bit give_done, input int dly, input int len,
                                 input int plen, input bit extra);
        int p, req, d, t, fin, q, last;
        nextEdge();
        p = cyc;
        go_btn = 1'b0;
        req = p + DB + 3;
        d   = req + dly;
        q   = p + plen + DB + 2;
        push(EV_GOFALL, req, 2);
        push(EV_GORISE, req + HOLD, 1);
        if (give_done) begin
            t   = (d + 3 > req + HOLD + 1) ? d + 3 : req + HOLD + 1;
            fin = d + len + 3;
            model_count = (model_count + 1) % 256;
            push(EV_RUNDONE, t, model_count);
            push(EV_IDLE, fin, 1);
        end else begin
            fin = req + TMO;
            push(EV_TERR, fin, model_count);
            push(EV_IDLE, fin, 1);
        end
        last = fin;
        if (p + plen + DB + 2 > last) last = p + plen + DB + 2;
        if (extra && q + 6 + DB + 2 > last) last = q + 6 + DB + 2;
        while (cyc < last + 3) begin
            nextEdge();
            if (cyc == p + plen) go_btn = 1'b1;
            if (extra && cyc == q) go_btn = 1'b0;
            if (extra && cyc == q + 6) go_btn = 1'b1;
            if (give_done && cyc == d) done_sig = 1'b1;
            if (give_done && cyc == d + len) done_sig = 1'b0;
        end
    endtask

    initial begin
        int p, req;

        repeat (3) nextEdge();
        checkOutput("reset_go_n", int'(go_n), 1);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_run_done", int'(run_done), 0);
        checkOutput("reset_timeout_err", int'(timeout_err), 0);
        checkOutput("reset_run_count", int'(run_count), 0);
        rst = 1'b0;
        repeat (3) nextEdge();

        // Clean press: done high 33 cycles after request start, for 20 cycles.
        applyStimulus(1'b1, 33, 20, 10, 1'b0);
        checkOutput("clean_run_count", int'(run_count), 1);

        // Bounce: short low glitches never reach the stability count.
        for (int i = 0; i < 5; i++) begin
            go_btn = 1'b0;
            repeat (2) nextEdge();
            go_btn = 1'b1;
            repeat (2) nextEdge();
        end
        repeat (15) nextEdge();
        checkOutput("bounce_go_n", int'(go_n), 1);
        checkOutput("bounce_busy", int'(busy), 0);

        // Timeout, then a fresh press that must clear the error (checked on go_n fall).
        applyStimulus(1'b0, 0, 0, 8, 1'b0);
        checkOutput("timeout_err_held", int'(timeout_err), 1);
        checkOutput("timeout_run_count", int'(run_count), 1);
        applyStimulus(1'b1, 1, 20, 7, 1'b0);

        // Second press while busy is discarded.
        applyStimulus(1'b1, 20, 15, 6, 1'b1);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 15 + $urandom_range(0, 15),
                          $urandom_range(10, 25), $urandom_range(6, 15),
                          ($urandom_range(0, 1) == 1));
        end

        // Asynchronous reset in the third cycle of go_n low.
        nextEdge();
        p = cyc;
        go_btn = 1'b0;
        req = p + DB + 3;
        push(EV_GOFALL, req, 2);
        while (cyc < req + 2) nextEdge();
        rst = 1'b1;
        #1;
        checkOutput("midreq_go_n", int'(go_n), 1);
        checkOutput("midreq_busy", int'(busy), 0);
        checkOutput("midreq_run_done", int'(run_done), 0);
        checkOutput("midreq_run_count", int'(run_count), 0);
        checkOutput("midreq_pending_events", exp_q.size(), 0);
        exp_q.delete();
        model_count = 0;
        go_btn = 1'b1;
        repeat (3) nextEdge();
        rst = 1'b0;
        repeat (DB + 10) nextEdge();
        applyStimulus(1'b1, 12, 12, 9, 1'b0);

        // 256 more completed runs carry run_count through 255 -> 0.
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, $urandom_range(0, 12), $urandom_range(10, 14),
                          $urandom_range(6, 10), 1'b0);
        end
        checkOutput("wrap_run_count", int'(run_count), 1);

        repeat (5) nextEdge();
        checkOutput("events_outstanding", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
